accum_unit: RTL and testbench
=============================

ACCUM_UNIT -- requirements
Module: accum_unit

Interface
REQ-001 Parameter N_OPS, default 4: operands accumulated per result, range 1..15.
REQ-002 Port clk, input, 1: single clock, all state on rising edge.
REQ-003 Port rst_n, input, 1: synchronous active-low reset.
REQ-004 Port in_valid, input, 1: operand offered.
REQ-005 Port in_ready, output, 1: unit can accept an operand.
REQ-006 Port x, input, 4: two's-complement operand.
REQ-007 Port sub, input, 1: sampled with x; 1 = subtract x, 0 = add x.
REQ-008 Port clear, input, 1: synchronous abort of the current accumulation.
REQ-009 Port out_valid, output, 1: result presented.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port acc, output, 4: running or final two's-complement sum.
REQ-012 Port overflow, output, 1: sticky; 1 if any step overflowed since the last result or clear.

Function
REQ-013 States SHALL be IDLE, ACC and DONE.
REQ-014 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE and ACC, and 0 in DONE.
REQ-016 On each transfer, the next acc SHALL be acc + x (sub=0) or acc + ~x + 1 (sub=1), computed as 4-bit addition with carry-in = sub.
REQ-017 Step overflow SHALL be carry-into-bit-3 XOR carry-out-of-bit-3, and SHALL be ORed into overflow.
REQ-018 An operand counter (4 bits) SHALL increment on each transfer.
REQ-019 Transitions on a transfer: IDLE->ACC, or IDLE->DONE when N_OPS=1; ACC->DONE on the transfer that makes the count equal N_OPS.
REQ-020 Result latency: out_valid SHALL rise on the cycle after the final transfer.
REQ-021 In DONE, acc and overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 DONE with out_ready=1: go to IDLE and clear acc, overflow and the counter to 0 on the next edge.
REQ-023 in_ready SHALL be 0 on the cycle of the DONE->IDLE handshake (no same-cycle accept).
REQ-024 clear=1 in any state: go to IDLE and zero acc, overflow and the counter, ignoring any coincident transfer.
REQ-025 out_valid SHALL be 1 only in DONE.
REQ-026 Operands with in_valid=1 while in_ready=0 SHALL be ignored; the source holds them.

Reset
REQ-027 rst_n=0 at a rising clk edge SHALL force IDLE with acc=0, overflow=0, counter=0, out_valid=0 and in_ready=1 the following cycle.
REQ-028 Reset SHALL take priority over clear, transfers and handshakes, including reset during ACC or DONE.

Configuration
REQ-029 Macro ACCUM_SAT_EN SHALL select overflow handling.
REQ-030 With ACCUM_SAT_EN defined, an overflowing step SHALL load 4'b0111 if the effective operands were non-negative, else 4'b1000; overflow SHALL still be set.
REQ-031 Without ACCUM_SAT_EN, an overflowing step SHALL load the wrapped 4-bit sum.

Structure
REQ-032 Package accum_pkg SHALL hold the state enum typedef (IDLE/ACC/DONE), the data-width constant 4 and the saturation constants 4'b0111 and 4'b1000.
REQ-033 The add step SHALL be one sub-module, cla_add4: 4-bit carry-lookahead with inputs cin, a, b and outputs s, c3, c4.
REQ-034 Control, counter and registers SHALL remain in accum_unit.

Verification
REQ-035 N_OPS=4, add 3, 2, 1, 1 back-to-back -> out_valid=1 one cycle later, acc=4'b0111, overflow=0.
REQ-036 N_OPS=2, add 5 then 4 -> acc=4'b1001, overflow=1; with ACCUM_SAT_EN -> acc=4'b0111, overflow=1.
REQ-037 N_OPS=1, sub=1, x=1 from reset -> acc=4'b1111, overflow=0; sub=1, x=4'b1000 -> overflow=1 (saturated build: acc=4'b0111).
REQ-038 In DONE, hold out_ready=0 for 3 cycles while in_valid=1 -> acc and overflow unchanged, no operand consumed, in_ready=0; then out_ready=1 -> next cycle IDLE, acc=0.
REQ-039 N_OPS=4, two transfers, then clear=1 together with in_valid=1 -> IDLE, acc=0, counter=0; the coincident operand is not accumulated.
REQ-040 rst_n=0 for one cycle during ACC -> next cycle acc=0, overflow=0, out_valid=0, in_ready=1; a full 4-operand sequence afterwards gives the correct sum.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator slice.
// Saturation constants are used only when ACCUM_SAT_EN is defined.
package accum_pkg;
  localparam int unsigned DATA_W = 4;

  localparam logic [DATA_W-1:0] SAT_POS = 4'b0111;
  localparam logic [DATA_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/cla_add4.sv
// 4-bit carry-lookahead adder. c3 is the carry into bit 3 and c4 the carry
// out of bit 3; their XOR gives two's-complement overflow.
module cla_add4
  import accum_pkg::*;
(
  input  logic              cin,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s,
  output logic              c3,
  output logic              c4
);

  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic              c1;
  logic              c2;

  assign g = a & b;
  assign p = a ^ b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & cin);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/accum_unit.sv
// Accumulates N_OPS signed 4-bit operands (add or subtract) and presents the
// sum with a sticky overflow flag. Define ACCUM_SAT_EN to saturate on overflow.
//
// state | meaning
// IDLE  | no operand taken yet, acc/overflow/counter are zero
// ACC   | at least one operand taken, waiting for the rest
// DONE  | result presented on acc/overflow until out_ready
module accum_unit
  import accum_pkg::*;
#(
  parameter int N_OPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x,
  input  logic              sub,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] acc,
  output logic              overflow
);

  localparam logic [3:0] N_OPS_C = 4'(N_OPS);

  state_t            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W-1:0] sum;
  logic              c3;
  logic              c4;
  logic              step_ovf;
  logic              xfer;

  // Subtraction as acc + ~x + 1: invert the operand, carry-in supplies the +1.
  assign b_eff = sub ? ~x : x;

  cla_add4 u_add (
    .cin (sub),
    .a   (acc_q),
    .b   (b_eff),
    .s   (sum),
    .c3  (c3),
    .c4  (c4)
  );

  assign step_ovf = c3 ^ c4;
  assign xfer     = in_valid & in_ready_q;
  assign cnt_d    = cnt_q + 4'd1;
  assign ovf_d    = ovf_q | step_ovf;

  always_comb begin
    acc_d = sum;
`ifdef ACCUM_SAT_EN
    // Overflow implies both effective operands share acc_q's sign.
    if (step_ovf) begin
      acc_d = acc_q[DATA_W-1] ? SAT_NEG : SAT_POS;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (xfer) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
            if (cnt_d == N_OPS_C) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc       = acc_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_accum_unit.sv
// Directed bench for accum_unit with N_OPS = 4, 2 and 1 instances on shared
// stimulus; expectations follow ACCUM_SAT_EN when it is defined.
module tb_accum_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] x = 4'd0;
  logic       sub = 1'b0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;

  logic       ir4, ov4, of4, ir2, ov2, of2, ir1, ov1, of1;
  logic [3:0] acc4, acc2, acc1;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef ACCUM_SAT_EN
  localparam logic [3:0] EXP_T10  = 4'b0111;
  localparam logic [3:0] EXP_5P4  = 4'b0111;
  localparam logic [3:0] EXP_SUB8 = 4'b0111;
`else
  localparam logic [3:0] EXP_T10  = 4'b1000;
  localparam logic [3:0] EXP_5P4  = 4'b1001;
  localparam logic [3:0] EXP_SUB8 = 4'b1000;
`endif

  always #5 clk = ~clk;

  accum_unit #(.N_OPS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .x(x),
    .sub(sub), .clear(clear), .out_valid(ov4), .out_ready(out_ready),
    .acc(acc4), .overflow(of4)
  );
  accum_unit #(.N_OPS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .x(x),
    .sub(sub), .clear(clear), .out_valid(ov2), .out_ready(out_ready),
    .acc(acc2), .overflow(of2)
  );
  accum_unit #(.N_OPS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .x(x),
    .sub(sub), .clear(clear), .out_valid(ov1), .out_ready(out_ready),
    .acc(acc1), .overflow(of1)
  );

  typedef struct {
    logic       iv;
    logic       sb;
    logic [3:0] xx;
    logic       clr;
    logic       ordy;
    logic [3:0] e_acc;
    logic       e_ovf;
    logic       e_ov;
    logic       e_ir;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic rst, input logic iv, input logic sb,
                       input logic [3:0] xx, input logic clr, input logic ordy);
    @(negedge clk);
    rst_n = rst; in_valid = iv; sub = sb; x = xx; clear = clr; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] ea, input logic eo,
                      input logic ev, input logic er);
    chk({tag, " acc"}, int'(acc4), int'(ea));
    chk({tag, " ovf"}, int'(of4), int'(eo));
    chk({tag, " out_valid"}, int'(ov4), int'(ev));
    chk({tag, " in_ready"}, int'(ir4), int'(er));
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    //          iv  sb  x       clr ordy  acc      ovf ov  ir
    vt[0]  = '{1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 4'd3,    1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 4'd5,    1'b0, 1'b0, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 4'd6,    1'b0, 1'b0, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 4'd7,    1'b0, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 4'd7,    1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 4'd7,    1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 4'd7,    1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 4'd0,    1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 4'd7,    1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, EXP_T10, 1'b1, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0,    1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 4'he,    1'b0, 1'b0, 1'b1};
    vt[12] = '{1'b1, 1'b1, 4'd1, 1'b0, 1'b0, 4'hd,    1'b0, 1'b0, 1'b1};
    vt[13] = '{1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 4'he,    1'b0, 1'b0, 1'b1};
    vt[14] = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 4'd6,    1'b0, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0,    1'b0, 1'b0, 1'b1};

    do_reset();
    chk4("reset", 4'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vt[i].iv, vt[i].sb, vt[i].xx, vt[i].clr, vt[i].ordy);
      chk4($sformatf("vec%0d", i), vt[i].e_acc, vt[i].e_ovf, vt[i].e_ov, vt[i].e_ir);
    end

    // N_OPS=2: 5 + 4 overflows
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
    chk("n2 first out_valid", int'(ov2), 0);
    drive(1'b1, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
    chk("n2 acc", int'(acc2), int'(EXP_5P4));
    chk("n2 ovf", int'(of2), 1);
    chk("n2 out_valid", int'(ov2), 1);

    // N_OPS=1: subtracts from reset
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    chk("n1 sub1 acc", int'(acc1), 15);
    chk("n1 sub1 ovf", int'(of1), 0);
    chk("n1 sub1 out_valid", int'(ov1), 1);
    chk("n1 sub1 in_ready", int'(ir1), 0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("n1 hs acc", int'(acc1), 0);
    drive(1'b1, 1'b1, 1'b1, 4'h8, 1'b0, 1'b0);
    chk("n1 sub8 acc", int'(acc1), int'(EXP_SUB8));
    chk("n1 sub8 ovf", int'(of1), 1);

    // clear with coincident operand, then a full run proves counter restarted
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    chk4("pre-clear", 4'd3, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
    chk4("clear", 4'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    chk4("post-clear 3rd", 4'd3, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    chk4("post-clear 4th", 4'd4, 1'b0, 1'b1, 1'b0);

    // reset during ACC wins over a coincident transfer
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    chk4("mid reset", 4'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    chk4("post-reset 3rd", 4'd5, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    chk4("post-reset 4th", 4'd6, 1'b0, 1'b1, 1'b0);

    // reset during DONE
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk4("reset in DONE", 4'd0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
